// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared constants for the Fibonacci evaluator and index finder
package fib_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SEARCH = 1'b1;

    // Largest index whose term fits in 32 bits, and that term
    localparam int          FIB_MAX_IDX_32 = 47;
    localparam logic [31:0] FIB_MAX_32     = 32'd2971215073;

endpackage

// File: rtl/fib_step.sv
// rtl/fib_step.sv - one Fibonacci recurrence step: next term = a + b
module fib_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] next_b
);

    // One extra bit of headroom so the first term past WIDTH is still visible
    assign next_b = a + b;

endmodule

// File: rtl/fib_index_finder.sv
// rtl/fib_index_finder.sv - smallest n with fib(n) >= value, one term per clock
module fib_index_finder
    import fib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] index,
    output logic             exact,
    output logic             ovf
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   b_q, b_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             exact_q, exact_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   next_b;
    logic             reached;

    fib_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_q),
        .b      (b_q),
        .next_b (next_b)
    );

    // Current term has caught up with the target (target zero-extended)
    assign reached = (a_q >= {1'b0, v_q});

    // Next-state: accept in IDLE, then walk the recurrence until a >= v or b overflows
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        v_d     = v_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        index_d = index_q;
        exact_d = exact_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    v_d     = value;
                    a_d     = '0;
                    b_d     = (WIDTH+1)'(1);
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SEARCH;
                end
            end
            default: begin
                if (reached) begin
                    index_d = k_q;
                    exact_d = (a_q == {1'b0, v_q});
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (b_q[WIDTH]) begin
                    // The next term no longer fits in WIDTH bits: no answer exists
                    index_d = k_q;
                    exact_d = 1'b0;
                    ovf_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    a_d = b_q;
                    b_d = next_b;
                    k_d = k_q + IDX_W'(1);
                end
            end
        endcase
    end

    // State and output registers; reset aborts any search without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= (WIDTH+1)'(1);
            v_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            index_q <= '0;
            exact_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            v_q     <= v_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            index_q <= index_d;
            exact_q <= exact_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign index = index_q;
    assign exact = exact_q;
    assign ovf   = ovf_q;

endmodule
